fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised IF stage: generates PCs, issues pipelined requests to an instruction memory port with variable
//  latency, and buffers returned words plus their PCs in a DEPTH-entry prefetch queue feeding decode (valid/ready).
//  Execute-stage redirects flush the queue and discard responses still in flight. Sits between the PC source and the
//  IF/ID boundary, replacing the single-PC fetch path.
// PARAMETERS
//  XLEN      32  address/instruction width (bits)
//  DEPTH     4   prefetch queue entries (power of 2, >=2)
//  MAX_OUTST 2   max outstanding imem requests (>=1, <=DEPTH)
//  RESET_PC  0   PC loaded on srst
// PORTS
//  clk             in  1     clock; all state on rising edge
//  srst            in  1     synchronous reset, active-high
//  imem_req_valid  out 1     request to instr memory
//  imem_req_ready  in  1     memory accepts request this cycle
//  imem_req_addr   out XLEN  word-aligned fetch address
//  imem_rsp_valid  in  1     in-order response valid
//  imem_rsp_data   in  XLEN  instruction word
//  pcsrc_e         in  1     redirect (taken branch/jal) from execute
//  pc_target_e     in  XLEN  redirect target
//  valid_f         out 1     instr_f/pc_f/pc_plus4_f valid to decode
//  ready_d         in  1     decode accepts (0 = stall)
//  instr_f         out XLEN  queue-head instruction
//  pc_f            out XLEN  queue-head PC
//  pc_plus4_f      out XLEN  pc_f + 4
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, outst=0, drop=0; imem_req_valid=0, valid_f=0, instr_f=0, pc_f=0 in reset
//    cycle; first request issues the cycle after srst deasserts. Reset mid-transaction: in-flight responses after
//    reset are ignored only if they arrive while srst=1; memory is reset with the unit.
//  - Issue: imem_req_valid = !pcsrc_e && outst<MAX_OUTST && (count+outst)<DEPTH (credit rule: never overflows).
//    Fire = valid&&ready -> fetch_pc += 4 (mod 2^XLEN wrap), outst++.
//  - Response: rsp_valid -> outst--; if drop>0 then drop-- (discard) else push {fetch PC FIFO head, data}.
//    Issued PCs held in a MAX_OUTST-deep tag FIFO so each response pairs with its address.
//  - Output: head exposed combinationally from queue; pop when valid_f&&ready_d. Min latency req->valid_f = mem
//    latency + 1 cycle. Push and pop same cycle on full or empty queue both legal; count unchanged.
//  - Redirect (pcsrc_e=1): queue flushed, valid_f forced 0 same cycle, fetch_pc<=pc_target_e, no issue this cycle;
//    drop <= outst - (rsp_valid?1:0) (+ responses still owed); tag FIFO cleared. Redirect takes priority over push/
//    pop/issue. Back-to-back redirects: last target wins, drop accumulates correctly.
//  - pc_plus4_f = pc_f + 4, XLEN bits, wrap silently. Misaligned pc_target_e: low 2 bits forced to 0.
//  - States: RUN (normal), DRAIN (drop>0; issue allowed, responses discarded). RUN->DRAIN on redirect with outst>0;
//    DRAIN->RUN when drop hits 0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles valid_f&&!ready_d), perf_flush_cnt[31:0]
//  (redirects), perf_drop_cnt[31:0] (discarded responses); saturating, cleared by srst. Undefined: ports and
//  counters absent, no other behaviour change.
// STRUCTURE
//  Package fetch_pkg: typedef fetch_entry_t {logic [XLEN-1:0] pc, instr}; localparam INSTR_NOP=32'h0000_0013;
//  typedef fetch_state_e {RUN, DRAIN}. Sub-module fetch_queue (sync FIFO, parametrised DEPTH/entry type, flush,
//  full/empty/count) instantiated twice: prefetch queue and PC tag FIFO.
// TESTING
//  1 Zero-latency mem, ready_d=1: after srst, PCs 0,4,8,C stream; valid_f first high 2 cycles after reset release.
//  2 ready_d=0 for 10 cycles, DEPTH=4: exactly 4 entries held, imem_req_valid drops, no lost/duplicate PC on resume.
//  3 Mem latency 3, MAX_OUTST=2, redirect to 0x100 with 2 in flight: both stale words dropped, next valid pc_f=0x100.
//  4 Redirect same cycle as rsp_valid and pop: queue empty next cycle, drop=outst-1, target fetched next.
//  5 pc_target_e=0xFFFF_FFFC: pc_plus4_f=0, next fetch addr 0x0 (wrap).
//  6 FETCH_PERF_EN: 5 stall cycles + 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2; srst clears to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the prefetching IF stage: queue entry, drain state, default NOP word.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, used for both the prefetch queue and the issued-PC tag FIFO.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     data_i,
  input  logic                       pop_i,
  output entry_t                     data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (srst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching IF stage: pipelined imem requests, PC tag FIFO, prefetch queue, redirect drain.
// Optional FETCH_PERF_EN adds saturating stall/flush/drop counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = FETCH_XLEN,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            srst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            valid_f,
  input  logic            ready_d,
  output logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTST+1);
  localparam int unsigned QCNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [OUT_W-1:0]  drop_q, drop_d;
  fetch_state_e      state_q, state_d;

  logic              fire, discard, rsp_keep, q_push, q_pop;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [QCNT_W-1:0] q_count;
  logic [OUT_W-1:0]  tag_count;
  fetch_entry_t      q_in, q_head;
  logic [XLEN-1:0]   tag_head;
  logic              unused_status;

  // Credit rule: queued plus in-flight words never exceed the queue depth.
  assign imem_req_valid = !srst && !pcsrc_e && (outst_q < OUT_W'(MAX_OUTST))
                          && ((32'(q_count) + 32'(outst_q)) < DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign discard  = (state_q == DRAIN);
  assign rsp_keep = imem_rsp_valid && !discard && !tag_empty;
  assign q_push   = rsp_keep && !pcsrc_e;
  assign q_pop    = valid_f && ready_d;
  assign q_in     = '{pc: FETCH_XLEN'(tag_head), instr: FETCH_XLEN'(imem_rsp_data)};

  fetch_queue #(.DEPTH(MAX_OUTST), .entry_t(logic [XLEN-1:0])) u_tag_fifo (
    .clk     (clk),
    .srst    (srst),
    .flush_i (pcsrc_e),
    .push_i  (fire),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_keep),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  fetch_queue #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_prefetch_q (
    .clk     (clk),
    .srst    (srst),
    .flush_i (pcsrc_e),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign unused_status = ^{tag_full, tag_count, q_full};

  assign valid_f    = !srst && !pcsrc_e && !q_empty;
  assign pc_f       = srst ? '0 : XLEN'(q_head.pc);
  assign instr_f    = srst ? '0 : (q_empty ? XLEN'(INSTR_NOP) : XLEN'(q_head.instr));
  assign pc_plus4_f = pc_f + XLEN'(4);

  // Every response still owed after a redirect belongs to the old path and is dropped.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    state_d    = state_q;
    if (pcsrc_e) begin
      fetch_pc_d = {pc_target_e[XLEN-1:2], 2'b00};
      outst_d    = outst_q - OUT_W'(imem_rsp_valid);
      drop_d     = outst_d;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outst_d = outst_q + OUT_W'(fire) - OUT_W'(imem_rsp_valid);
      if (imem_rsp_valid && discard) drop_d = drop_q - 1'b1;
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      state_q    <= RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (valid_f && !ready_d && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pcsrc_e && (flush_cnt_q != '1))             flush_cnt_q <= flush_cnt_q + 32'd1;
      if (imem_rsp_valid && discard && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a fixed-latency in-order imem model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        srst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pcsrc_e;
  logic [31:0] pc_target_e;
  logic        valid_f, ready_d;
  logic [31:0] instr_f, pc_f, pc_plus4_f;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  logic [3:0]  v_pipe;
  logic [31:0] a_pipe [4];

  fetch_prefetch_unit dut (
    .clk            (clk),
    .srst           (srst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pcsrc_e        (pcsrc_e),
    .pc_target_e    (pc_target_e),
    .valid_f        (valid_f),
    .ready_d        (ready_d),
    .instr_f        (instr_f),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory answers an accepted request exactly lat cycles later, in order; reset with the unit.
  always @(posedge clk) begin
    if (srst) begin
      v_pipe <= '0;
    end else begin
      v_pipe    <= {v_pipe[2:0], imem_req_valid && imem_req_ready};
      a_pipe[0] <= imem_req_addr;
      for (int k = 1; k < 4; k++) a_pipe[k] <= a_pipe[k-1];
    end
  end
  assign imem_rsp_valid = v_pipe[lat-1];
  assign imem_rsp_data  = mem_word(a_pipe[lat-1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expects n consecutive cycles of valid output with sequential PCs starting at pc0.
  task automatic stream(input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check("stream_valid", 32'(valid_f), 32'd1);
      check("stream_pc", pc_f, pc);
      check("stream_instr", instr_f, mem_word(pc));
      check("stream_pc4", pc_plus4_f, pc + 32'd4);
      pc = pc + 32'd4;
    end
  endtask

  task automatic expect_next(input logic [31:0] pc);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!valid_f && k < 20);
    check("next_valid", 32'(valid_f), 32'd1);
    check("next_pc", pc_f, pc);
    check("next_instr", instr_f, mem_word(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    srst = 1'b1; ready_d = 1'b1; pcsrc_e = 1'b0; pc_target_e = '0;
    imem_req_ready = 1'b1; lat = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_valid_f", 32'(valid_f), 32'd0);
    check("rst_instr_f", instr_f, 32'd0);
    check("rst_pc_f", pc_f, 32'd0);

    // Zero-wait memory streaming after reset release
    @(negedge clk); srst = 1'b0; #1;
    check("t1_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_req_addr0", imem_req_addr, 32'h0);
    check("t1_valid_c0", 32'(valid_f), 32'd0);
    @(negedge clk); #1;
    check("t1_req_addr1", imem_req_addr, 32'h4);
    check("t1_valid_c1", 32'(valid_f), 32'd0);
    stream(32'h0, 4);

    // Redirect coinciding with a response and a pop attempt
    @(negedge clk); pcsrc_e = 1'b1; pc_target_e = 32'h200; #1;
    check("t4_valid_flush", 32'(valid_f), 32'd0);
    check("t4_req_block", 32'(imem_req_valid), 32'd0);
    @(negedge clk); pcsrc_e = 1'b0; #1;
    check("t4_empty", 32'(valid_f), 32'd0);
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h200);
    @(negedge clk); #1;
    check("t4_wait", 32'(valid_f), 32'd0);
    stream(32'h200, 3);

    // Misaligned target near the top of the address space
    @(negedge clk); pcsrc_e = 1'b1; pc_target_e = 32'hFFFF_FFFD; #1;
    check("t5_valid_flush", 32'(valid_f), 32'd0);
    @(negedge clk); pcsrc_e = 1'b0; #1;
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("t5_wrap_addr", imem_req_addr, 32'h0);
    check("t5_wait", 32'(valid_f), 32'd0);
    stream(32'hFFFF_FFFC, 2);

    // Decode stall fills the queue, then resumes without loss
    @(negedge clk); srst = 1'b1; ready_d = 1'b0;
    @(negedge clk);
    @(negedge clk); srst = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("t2_req_stop", 32'(imem_req_valid), 32'd0);
    check("t2_next_addr", imem_req_addr, 32'h10);
    check("t2_valid", 32'(valid_f), 32'd1);
    check("t2_head_pc", pc_f, 32'h0);
    @(negedge clk); ready_d = 1'b1; #1;
    check("t2_resume_pc", pc_f, 32'h0);
    stream(32'h4, 5);

    // Reset with a non-empty queue hides the head in the reset cycle
    @(negedge clk); srst = 1'b1; #1;
    check("rst2_valid_f", 32'(valid_f), 32'd0);
    check("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst2_pc_f", pc_f, 32'd0);
    check("rst2_instr_f", instr_f, 32'd0);

    // Latency 3: redirect with two requests in flight
    @(negedge clk); lat = 3;
    @(negedge clk); srst = 1'b0; #1;
    check("t3_req_addr0", imem_req_addr, 32'h0);
    @(negedge clk); #1;
    check("t3_req_addr1", imem_req_addr, 32'h4);
    @(negedge clk); pcsrc_e = 1'b1; pc_target_e = 32'h100; #1;
    check("t3_valid_flush", 32'(valid_f), 32'd0);
    @(negedge clk); pcsrc_e = 1'b0; #1;
    check("t3_credit_block", 32'(imem_req_valid), 32'd0);
    @(negedge clk); #1;
    check("t3_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_req_target", imem_req_addr, 32'h100);
    expect_next(32'h100);
    expect_next(32'h104);

    // Back-to-back redirects: last target wins
    @(negedge clk); pcsrc_e = 1'b1; pc_target_e = 32'h300;
    @(negedge clk); pc_target_e = 32'h400;
    @(negedge clk); pcsrc_e = 1'b0;
    expect_next(32'h400);
    expect_next(32'h404);

`ifdef FETCH_PERF_EN
    @(negedge clk); srst = 1'b1; lat = 1;
    @(negedge clk); #1;
    check("perf_rst_stall", perf_stall_cnt, 32'd0);
    check("perf_rst_flush", perf_flush_cnt, 32'd0);
    @(negedge clk); srst = 1'b0;
    @(negedge clk);
    @(negedge clk); ready_d = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk); ready_d = 1'b1;
    @(negedge clk); pcsrc_e = 1'b1; pc_target_e = 32'h40;
    @(negedge clk); pc_target_e = 32'h80;
    @(negedge clk); pcsrc_e = 1'b0; #1;
    check("perf_stall", perf_stall_cnt, 32'd5);
    check("perf_flush", perf_flush_cnt, 32'd2);
    check("perf_drop", perf_drop_cnt, 32'd0);
    expect_next(32'h80);
    @(negedge clk); srst = 1'b1;
    @(negedge clk); #1;
    check("perf_clr_stall", perf_stall_cnt, 32'd0);
    check("perf_clr_flush", perf_flush_cnt, 32'd0);
    check("perf_clr_drop", perf_drop_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
